// File: rtl/logic_gate_unit.sv
`default_nettype none
// ============================================================================
// Module   : logic_gate_unit
// Purpose  : Bitwise gate unit behind a single-entry valid/ready register,
//            with a saturating transfer counter and a sticky illegal-op flag.
// Revision : 1.0
// ============================================================================
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       y_op,
  output logic             y_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] count,
  input  logic             clr_stats
);

  localparam logic [2:0] c_op_not     = 3'b000;
  localparam logic [2:0] c_op_and     = 3'b001;
  localparam logic [2:0] c_op_or      = 3'b010;
  localparam logic [2:0] c_op_nand    = 3'b011;
  localparam logic [2:0] c_op_nor     = 3'b100;
  localparam logic [2:0] c_op_xor     = 3'b101;
  localparam logic [2:0] c_op_xnor    = 3'b110;
  localparam logic [2:0] c_op_illegal = 3'b111;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic [2:0]       r_y_op;
  logic             r_y_err;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_count;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_illegal;
  logic [WIDTH-1:0] w_result;

  // The register may refill on the same edge it drains.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_illegal  = (op == c_op_illegal);

  always_comb begin
    w_result = '0;
    case (op)
      c_op_not:  w_result = ~a;
      c_op_and:  w_result = a & b;
      c_op_or:   w_result = a | b;
      c_op_nand: w_result = ~(a & b);
      c_op_nor:  w_result = ~(a | b);
      c_op_xor:  w_result = a ^ b;
      c_op_xnor: w_result = ~(a ^ b);
      default:   w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_y          <= '0;
      r_y_op       <= 3'b000;
      r_y_err      <= 1'b0;
      r_err_sticky <= 1'b0;
      r_count      <= '0;
    end else begin
      if (w_in_fire) begin
        r_out_valid <= 1'b1;
        r_y         <= w_result;
        r_y_op      <= op;
        r_y_err     <= w_illegal;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end

      // Clearing wins over a same-edge increment or sticky set.
      if (clr_stats) begin
        r_count      <= '0;
        r_err_sticky <= 1'b0;
      end else begin
        if (w_out_fire && (r_count != c_cnt_max)) begin
          r_count <= r_count + CNT_W'(1);
        end
        if (w_in_fire && w_illegal) begin
          r_err_sticky <= 1'b1;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign y          = r_y;
  assign y_op       = r_y_op;
  assign y_err      = r_y_err;
  assign err_sticky = r_err_sticky;
  assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_gate_unit
// Purpose  : Directed and random checks of logic_gate_unit at three sizings.
// Revision : 1.0
// ============================================================================
module tb_logic_gate_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, clr_stats;
  logic [2:0] op;
  logic [7:0] a, b;

  logic        in_ready_a, out_valid_a, y_err_a, err_sticky_a;
  logic [7:0]  y_a;
  logic [2:0]  y_op_a;
  logic [15:0] count_a;

  logic        in_ready_b, out_valid_b, y_err_b, err_sticky_b;
  logic [7:0]  y_b;
  logic [2:0]  y_op_b;
  logic [1:0]  count_b;

  logic        in_ready_c, out_valid_c, y_err_c, err_sticky_c;
  logic [0:0]  y_c;
  logic [2:0]  y_op_c;
  logic [15:0] count_c;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(8), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .op(op), .a(a), .b(b), .out_valid(out_valid_a), .out_ready(out_ready),
    .y(y_a), .y_op(y_op_a), .y_err(y_err_a), .err_sticky(err_sticky_a),
    .count(count_a), .clr_stats(clr_stats)
  );

  logic_gate_unit #(.WIDTH(8), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .op(op), .a(a), .b(b), .out_valid(out_valid_b), .out_ready(out_ready),
    .y(y_b), .y_op(y_op_b), .y_err(y_err_b), .err_sticky(err_sticky_b),
    .count(count_b), .clr_stats(clr_stats)
  );

  logic_gate_unit #(.WIDTH(1), .CNT_W(16)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .op(op), .a(a[0:0]), .b(b[0:0]), .out_valid(out_valid_c), .out_ready(out_ready),
    .y(y_c), .y_op(y_op_c), .y_err(y_err_c), .err_sticky(err_sticky_c),
    .count(count_c), .clr_stats(clr_stats)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: one holding slot, last-loaded result, transfer total, sticky flag.
  bit         m_valid;
  logic [7:0] m_y;
  logic [2:0] m_op;
  bit         m_err;
  bit         m_sticky;
  int         m_cnt;
  bit         last_in_fire;

  function automatic logic [7:0] gate(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0:    return ~x;
      3'd1:    return x & z;
      3'd2:    return x | z;
      3'd3:    return ~(x & z);
      3'd4:    return ~(x | z);
      3'd5:    return x ^ z;
      3'd6:    return ~(x ^ z);
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_y      = '0;
    m_op     = '0;
    m_err    = 1'b0;
    m_sticky = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid_a), 64'(m_valid));
    chk("in_ready", 64'(in_ready_a), 64'(!m_valid || out_ready));
    chk("y", 64'(y_a), 64'(m_y));
    chk("y_op", 64'(y_op_a), 64'(m_op));
    chk("y_err", 64'(y_err_a), 64'(m_err));
    chk("err_sticky", 64'(err_sticky_a), 64'(m_sticky));
    chk("count", 64'(count_a), 64'(m_cnt));
    chk("count_cntw2", 64'(count_b), 64'((m_cnt > 3) ? 3 : m_cnt));
    chk("y_width1", 64'(y_c), 64'(m_y[0]));
  endtask

  // Advance one rising edge, update the reference, then check just after it.
  task automatic tick();
    bit ir, inf, outf;
    @(posedge clk);
    ir   = !m_valid || out_ready;
    inf  = in_valid && ir;
    outf = m_valid && out_ready;
    if (outf) m_cnt++;
    if (inf) begin
      m_y     = gate(op, a, b);
      m_op    = op;
      m_err   = (op == 3'b111);
      m_valid = 1'b1;
      if (op == 3'b111) m_sticky = 1'b1;
    end else if (outf) begin
      m_valid = 1'b0;
    end
    if (clr_stats) begin
      m_cnt    = 0;
      m_sticky = 1'b0;
    end
    last_in_fire = inf;
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    in_valid = v;
    op       = o;
    a        = x;
    b        = z;
  endtask

  logic [7:0] tt_exp [7];
  int         sat_exp [5];

  initial begin
    tt_exp  = '{8'h0F, 8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3};
    sat_exp = '{1, 2, 3, 3, 3};
    rst_n = 1'b0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    model_reset();
    #2;
    check_all();
    chk("reset_in_ready", 64'(in_ready_a), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Truth table with a free-running sink.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 3'(i), 8'hF0, 8'hCC);
      tick();
      chk("truth_table", 64'(y_a), 64'(tt_exp[i]));
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    chk("truth_table_count", 64'(count_a), 64'(7));

    // Backpressure: first beat held, later beats drain in order.
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 8'h12, 8'h34);
    tick();
    drive(1'b1, 3'd5, 8'hA5, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_y", 64'(y_a), 64'(8'h10));
      chk("bp_in_ready", 64'(in_ready_a), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_beat2", 64'(y_a), 64'(8'hAA));
    drive(1'b1, 3'd3, 8'hFF, 8'h81);
    tick();
    chk("bp_beat3", 64'(y_a), 64'(8'h7E));
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    tick();

    // Illegal op and sticky flag, then clear on a draining edge.
    drive(1'b1, 3'd7, 8'hFF, 8'h00);
    tick();
    chk("illegal_y", 64'(y_a), 64'(0));
    chk("illegal_y_err", 64'(y_err_a), 64'(1));
    chk("illegal_sticky", 64'(err_sticky_a), 64'(1));
    drive(1'b1, 3'd1, 8'hFF, 8'h0F);
    tick();
    chk("legal_after_y_err", 64'(y_err_a), 64'(0));
    chk("legal_after_sticky", 64'(err_sticky_a), 64'(1));
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_sticky", 64'(err_sticky_a), 64'(0));
    chk("clr_count", 64'(count_a), 64'(0));

    // Saturation on the 2-bit counter, then clear beside a transfer.
    drive(1'b1, 3'd2, 8'h01, 8'h02);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd2, 8'(i), 8'h40);
      tick();
      chk("sat_count", 64'(count_b), 64'(sat_exp[i]));
    end
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("sat_clr_with_transfer", 64'(count_b), 64'(0));
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    tick();

    // Random traffic against the reference.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      out_ready = 1'($urandom_range(0, 3) != 0);
      clr_stats = 1'($urandom_range(0, 15) == 0);
      tick();
    end
    clr_stats = 1'b0;

    // Reset while a beat is held under backpressure.
    out_ready = 1'b0;
    drive(1'b1, 3'd5, 8'h3C, 8'hFF);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid_a), 64'(0));
    chk("rst_count", 64'(count_a), 64'(0));
    model_reset();
    check_all();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'd0, 8'hAA, 8'h00);
    tick();
    chk("post_reset_first_beat", 64'(y_a), 64'(8'h55));

    // Single-bit instance in NOT mode with toggling input.
    drive(1'b1, 3'd0, 8'h00, 8'h00);
    tick();
    chk("w1_not_0", 64'(y_c), 64'(1));
    drive(1'b1, 3'd0, 8'h01, 8'h00);
    tick();
    chk("w1_not_1", 64'(y_c), 64'(0));
    drive(1'b1, 3'd0, 8'h00, 8'h00);
    tick();
    chk("w1_not_2", 64'(y_c), 64'(1));
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
